// File: rtl/dmem_pkg.sv
// Shared types and limits for the data-memory responder.
package dmem_pkg;

    localparam int unsigned LAT_MAX   = 15;
    localparam int unsigned IDX_MAX_W = 30;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic                 we;
        logic [IDX_MAX_W-1:0] idx;
        logic [31:0]          wdata;
    } req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// CPU-side load/store handshake bundle; err_o exists only with DMEM_MISALIGN_ERR_EN.
interface dmem_responder_if;

    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        stall_o;
`ifdef DMEM_MISALIGN_ERR_EN
    logic        err_o;
`endif

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output ready_o, rvalid_o, rdata_o, stall_o
`ifdef DMEM_MISALIGN_ERR_EN
        , output err_o
`endif
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  ready_o, rvalid_o, rdata_o, stall_o
`ifdef DMEM_MISALIGN_ERR_EN
        , input err_o
`endif
    );

endinterface

// File: rtl/dmem_lat_counter.sv
// Loadable 4-bit down-counter that saturates at zero; done flags a zero count.
module dmem_lat_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       done
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 4'd1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder over a word-addressed array.
// Optional DMEM_MISALIGN_ERR_EN adds err_o and suppresses misaligned accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 32,
    parameter int unsigned LATENCY     = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_responder_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned LAT   = (LATENCY > LAT_MAX) ? LAT_MAX :
                                    (LATENCY < 1)       ? 1 : LATENCY;
    // WAIT lasts LAT-1 cycles; the counter's final zero cycle is the last one.
    localparam logic [3:0]  WAIT_LOAD = 4'((LAT > 1) ? (LAT - 2) : 0);

    state_t      state, state_next;
    req_t        req_in, req_q, req_sel;
    logic        mis_in, mis_q, mis_sel;
    logic        accept, complete, cnt_done, do_write, do_read;
    logic [31:0] rdata_q;
    logic [31:0] mem [DEPTH_WORDS];
    logic        unused_bits;

    assign req_in.we    = bus.we_i;
    assign req_in.idx   = IDX_MAX_W'(bus.addr_i[IDX_W+1:2]);
    assign req_in.wdata = bus.wdata_i;
`ifdef DMEM_MISALIGN_ERR_EN
    assign mis_in = (bus.addr_i[1:0] != 2'b00);
    assign unused_bits = ^{bus.addr_i[31:IDX_W+2], req_sel.idx[IDX_MAX_W-1:IDX_W]};
`else
    assign mis_in = 1'b0;
    assign unused_bits = ^{bus.addr_i[31:IDX_W+2], bus.addr_i[1:0],
                           req_sel.idx[IDX_MAX_W-1:IDX_W]};
`endif

    assign accept = (state == IDLE) && bus.req_i;

    // With LAT==1 the accept edge is also the completion edge, so use live inputs.
    assign req_sel = (state == IDLE) ? req_in : req_q;
    assign mis_sel = (state == IDLE) ? mis_in : mis_q;

    dmem_lat_counter u_cnt (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .load     (accept),
        .load_val (WAIT_LOAD),
        .en       (state == WAIT),
        .done     (cnt_done)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            req_q <= '0;
            mis_q <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                req_q <= req_in;
                mis_q <= mis_in;
            end
        end
    end

    always_comb begin
        state_next = state;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_i) begin
                    if (LAT > 1) begin
                        state_next = WAIT;
                    end else begin
                        state_next = RESP;
                        complete   = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_done) begin
                    state_next = RESP;
                    complete   = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign do_write = complete && req_sel.we && !mis_sel;
    assign do_read  = complete && !req_sel.we;

    // Array contents deliberately carry no reset.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem[req_sel.idx[IDX_W-1:0]] <= req_sel.wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
        end else if (do_read) begin
            rdata_q <= mis_sel ? '0 : mem[req_sel.idx[IDX_W-1:0]];
        end
    end

    assign bus.ready_o  = (state == IDLE);
    assign bus.rvalid_o = (state == RESP);
    assign bus.stall_o  = accept || (state == WAIT);
    assign bus.rdata_o  = rdata_q;
`ifdef DMEM_MISALIGN_ERR_EN
    assign bus.err_o    = (state == RESP) && mis_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder at LATENCY 4 and 1 against a transaction-level model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req, we;
    logic [31:0] addr, wdata;

    always #5 clk = ~clk;

    dmem_responder_if bus4 ();
    dmem_responder_if bus1 ();

    assign bus4.req_i   = req && (sel == 1'b0);
    assign bus1.req_i   = req && (sel == 1'b1);
    assign bus4.we_i    = we;
    assign bus1.we_i    = we;
    assign bus4.addr_i  = addr;
    assign bus1.addr_i  = addr;
    assign bus4.wdata_i = wdata;
    assign bus1.wdata_i = wdata;

    dmem_responder #(.DEPTH_WORDS(32), .LATENCY(4)) dut4 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus4.slave)
    );

    dmem_responder #(.DEPTH_WORDS(32), .LATENCY(1)) dut1 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus1.slave)
    );

    logic        ready_obs, rvalid_obs, stall_obs;
    logic [31:0] rdata_obs;
    assign ready_obs  = sel ? bus1.ready_o  : bus4.ready_o;
    assign rvalid_obs = sel ? bus1.rvalid_o : bus4.rvalid_o;
    assign stall_obs  = sel ? bus1.stall_o  : bus4.stall_o;
    assign rdata_obs  = sel ? bus1.rdata_o  : bus4.rdata_o;
`ifdef DMEM_MISALIGN_ERR_EN
    logic err_obs;
    assign err_obs = sel ? bus1.err_o : bus4.err_o;
`endif

    // Reference: per-instance word store, written-flags, and last returned load data.
    logic [31:0] mem_m    [2][32];
    bit          known    [2][32];
    logic [31:0] rd_m     [2];
    bit          rd_known [2];
    int          lat_of   [2] = '{4, 1};
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic access(input int s, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input bit junk);
        int lat;
        int i;
        bit mis;
        lat = lat_of[s];
        i   = int'(a[6:2]);
`ifdef DMEM_MISALIGN_ERR_EN
        mis = (a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        sel = s[0]; req = 1'b1; we = w; addr = a; wdata = d;
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            if (k == lat) begin
                if (!w) begin
                    if (mis) begin
                        rd_m[s] = '0; rd_known[s] = 1'b1;
                    end else begin
                        rd_m[s] = mem_m[s][i]; rd_known[s] = known[s][i];
                    end
                end else if (!mis) begin
                    mem_m[s][i] = d; known[s][i] = 1'b1;
                end
            end
            check("ready",  32'(ready_obs),  32'(k == 0));
            check("stall",  32'(stall_obs),  32'(k < lat));
            check("rvalid", 32'(rvalid_obs), 32'(k == lat));
            if (rd_known[s]) check("rdata", rdata_obs, rd_m[s]);
`ifdef DMEM_MISALIGN_ERR_EN
            check("err", 32'(err_obs), 32'((k == lat) && mis));
`endif
            @(posedge clk); #1;
            if (junk && k < lat) begin
                req = 1'b1; we = 1'($urandom); addr = $urandom; wdata = $urandom;
            end else begin
                req = 1'b0;
            end
        end
        req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check("idle_ready",  32'(ready_obs),  32'd1);
            check("idle_stall",  32'(stall_obs),  32'd0);
            check("idle_rvalid", 32'(rvalid_obs), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        for (int s = 0; s < 2; s++) begin
            for (int j = 0; j < 32; j++) known[s][j] = 1'b0;
            rd_m[s] = '0; rd_known[s] = 1'b1;
        end
        #2;
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            check("rst_ready",  32'(ready_obs),  32'd1);
            check("rst_rvalid", 32'(rvalid_obs), 32'd0);
            check("rst_stall",  32'(stall_obs),  32'd0);
            check("rst_rdata",  rdata_obs,       32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Latency 4 store then load
        access(0, 1'b1, 32'h10, 32'h12345678, 1'b0);
        access(0, 1'b0, 32'h10, 32'h0, 1'b0);
        check("lat4_load", rdata_obs, 32'h12345678);
        // Latency 1
        access(1, 1'b1, 32'h10, 32'hCAFEF00D, 1'b0);
        access(1, 1'b0, 32'h10, 32'h0, 1'b0);
        check("lat1_load", rdata_obs, 32'hCAFEF00D);
        // Busy requests ignored, back-to-back accept after RESP
        access(0, 1'b1, 32'h20, 32'h55AA55AA, 1'b1);
        access(0, 1'b0, 32'h20, 32'h0, 1'b1);
        access(1, 1'b0, 32'h10, 32'h0, 1'b1);
        // Index wrap modulo 32 words
        access(0, 1'b1, 32'h80, 32'hA5A5A5A5, 1'b0);
        access(0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("wrap_load", rdata_obs, 32'hA5A5A5A5);
        // Misaligned store
        access(0, 1'b1, 32'h4, 32'h01020304, 1'b0);
        access(0, 1'b1, 32'h6, 32'hFFFF0000, 1'b0);
        access(0, 1'b0, 32'h4, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_ERR_EN
        check("misalign_word", rdata_obs, 32'h01020304);
`else
        check("misalign_word", rdata_obs, 32'hFFFF0000);
`endif

        // Reset in the middle of a store's WAIT phase
        access(0, 1'b1, 32'h8, 32'h11111111, 1'b0);
        sel = 1'b0; req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            check("midrst_ready",  32'(ready_obs),  32'd1);
            check("midrst_rvalid", 32'(rvalid_obs), 32'd0);
            check("midrst_stall",  32'(stall_obs),  32'd0);
            check("midrst_rdata",  rdata_obs,       32'd0);
            rd_m[s] = '0; rd_known[s] = 1'b1;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        access(0, 1'b0, 32'h8, 32'h0, 1'b0);
        check("rst_discard", rdata_obs, 32'h11111111);

        // Random traffic over a small, heavily reused address set
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = ($urandom & 32'hF000_0000) | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
            access(int'($urandom_range(0, 1)), 1'($urandom), a, $urandom,
                   1'($urandom_range(0, 1)));
            idle(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
